// File: rtl/bcd_counter_multi.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter_multi
// Description : DIGITS-decade BCD up/down counter with load, clear and a
//               chainable terminal-count carry/borrow output.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_multi #(
    parameter int                      DIGITS   = 4,
    parameter logic [4*DIGITS-1:0]     INIT_VAL = '0
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Clr,
    input  logic                   Load,
    input  logic [4*DIGITS-1:0]    Load_val,
    input  logic                   Up_Dn,
    input  logic                   Cin,
    output logic [4*DIGITS-1:0]    q,
    output logic                   Cout,
    output logic                   Load_err
);

    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;

    // all9[k] / all0[k]: every digit below k is 9 / 0 (enables digit k)
    logic [DIGITS:0]     w_all9;
    logic [DIGITS:0]     w_all0;
    logic [4*DIGITS-1:0] w_up;
    logic [4*DIGITS-1:0] w_dn;
    logic [4*DIGITS-1:0] w_load_clean;
    logic [DIGITS-1:0]   w_load_bad;

    assign w_all9[0] = 1'b1;
    assign w_all0[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] w_cur;
        logic [3:0] w_ld;

        assign w_cur = cnt_q[4*g +: 4];
        assign w_ld  = Load_val[4*g +: 4];

        assign w_all9[g+1] = w_all9[g] & (w_cur == 4'd9);
        assign w_all0[g+1] = w_all0[g] & (w_cur == 4'd0);

        assign w_up[4*g +: 4] = !w_all9[g]       ? w_cur :
                                (w_cur == 4'd9)  ? 4'd0  : w_cur + 4'd1;
        assign w_dn[4*g +: 4] = !w_all0[g]       ? w_cur :
                                (w_cur == 4'd0)  ? 4'd9  : w_cur - 4'd1;

        assign w_load_bad[g]            = (w_ld > 4'd9);
        assign w_load_clean[4*g +: 4]   = w_load_bad[g] ? 4'd0 : w_ld;
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (Clr) begin
            cnt_d = INIT_VAL;
        end else if (Load) begin
            cnt_d = w_load_clean;
            err_d = |w_load_bad;
        end else if (Cin) begin
            cnt_d = Up_Dn ? w_up : w_dn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= INIT_VAL;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Asserted in the wrapping cycle so a downstream Cin can tie straight here
    assign Cout     = Cin & ~Rst & ~Clr & ~Load &
                      (Up_Dn ? w_all9[DIGITS] : w_all0[DIGITS]);
    assign q        = cnt_q;
    assign Load_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_counter_multi
// Description : Self-checking bench: vector table, directed sequences,
//               random stimulus against an integer reference model, cascade.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_multi;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst, Clr, Load, Up_Dn, Cin;
    logic [15:0] Load_val;
    logic [15:0] q;
    logic        Cout, Load_err;

    bcd_counter_multi #(.DIGITS(4), .INIT_VAL(16'h0000)) dut (
        .Clk(Clk), .Rst(Rst), .Clr(Clr), .Load(Load), .Load_val(Load_val),
        .Up_Dn(Up_Dn), .Cin(Cin), .q(q), .Cout(Cout), .Load_err(Load_err)
    );

    logic       c_rst, c_cin;
    logic [3:0] c0_q, c1_q;
    logic       c0_cout, c1_cout, c0_err, c1_err;

    bcd_counter_multi #(.DIGITS(1), .INIT_VAL(4'h0)) u_c0 (
        .Clk(Clk), .Rst(c_rst), .Clr(1'b0), .Load(1'b0), .Load_val(4'h0),
        .Up_Dn(1'b1), .Cin(c_cin), .q(c0_q), .Cout(c0_cout), .Load_err(c0_err)
    );
    bcd_counter_multi #(.DIGITS(1), .INIT_VAL(4'h0)) u_c1 (
        .Clk(Clk), .Rst(c_rst), .Clr(1'b0), .Load(1'b0), .Load_val(4'h0),
        .Up_Dn(1'b1), .Cin(c0_cout), .q(c1_q), .Cout(c1_cout), .Load_err(c1_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic bcd_ok(input logic [15:0] v);
        logic ok = 1'b1;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Drive inputs after the falling edge, check Cout before the rising edge,
    // then check the registered outputs just after it.
    task automatic step(input logic rst, clr, ld, input logic [15:0] val,
                        input logic ud, ci, input logic e_cout,
                        input logic [15:0] e_q, input logic e_err, input string tag);
        @(negedge Clk);
        Rst = rst; Clr = clr; Load = ld; Load_val = val; Up_Dn = ud; Cin = ci;
        #1 chk({tag, " Cout"}, {31'd0, Cout}, {31'd0, e_cout});
        @(posedge Clk);
        #1;
        chk({tag, " q"}, {16'd0, q}, {16'd0, e_q});
        chk({tag, " Load_err"}, {31'd0, Load_err}, {31'd0, e_err});
        chk({tag, " bcd"}, {31'd0, bcd_ok(q)}, 32'd1);
    endtask

    // Reference model: the count as a plain integer 0..9999
    int   m_val;
    logic m_err;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_step(input logic rst, clr, ld, input logic [15:0] val,
                              input logic ud, ci, input string tag);
        logic e_cout;
        logic term;
        int   d;
        term   = ud ? (m_val == 9999) : (m_val == 0);
        e_cout = ci & !rst & !clr & !ld & term;
        if (rst || clr) begin
            m_val = 0; m_err = 1'b0;
        end else if (ld) begin
            m_val = 0; m_err = 1'b0;
            for (int i = 3; i >= 0; i--) begin
                d = int'(val[4*i +: 4]);
                if (d > 9) begin m_err = 1'b1; d = 0; end
                m_val = m_val * 10 + d;
            end
        end else begin
            m_err = 1'b0;
            if (ci) m_val = ud ? (m_val + 1) % 10000 : (m_val + 9999) % 10000;
        end
        step(rst, clr, ld, val, ud, ci, e_cout, to_bcd(m_val), m_err, tag);
    endtask

    typedef struct {
        logic        rst, clr, ld;
        logic [15:0] val;
        logic        ud, ci;
        logic        e_cout;
        logic [15:0] e_q;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, clr, ld, input logic [15:0] val,
                                input logic ud, ci, e_cout, input logic [15:0] e_q,
                                input logic e_err);
        vec_t v;
        v.rst = rst; v.clr = clr; v.ld = ld; v.val = val; v.ud = ud; v.ci = ci;
        v.e_cout = e_cout; v.e_q = e_q; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        Rst = 1'b1; Clr = 1'b0; Load = 1'b0; Load_val = '0; Up_Dn = 1'b1; Cin = 1'b0;
        c_rst = 1'b1; c_cin = 1'b0;

        //            rst clr ld  val       ud ci cout q        err
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 1, 16'h12AF, 1, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 1, 16'h0997, 1, 0, 0, 16'h0997, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0998, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0998, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0999, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h1000, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h1000, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h1001, 0));
        tbl.push_back(mk(0, 0, 1, 16'h9999, 1, 0, 0, 16'h9999, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 1, 16'h1000, 0, 0, 0, 16'h1000, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0999, 0));
        tbl.push_back(mk(0, 0, 1, 16'h0000, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 16'h9999, 0));
        tbl.push_back(mk(0, 0, 1, 16'h12AF, 1, 0, 0, 16'h1200, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h1200, 0));
        tbl.push_back(mk(0, 0, 1, 16'h4321, 1, 0, 0, 16'h4321, 0));
        tbl.push_back(mk(0, 0, 1, 16'h0005, 1, 1, 0, 16'h0005, 0));
        tbl.push_back(mk(0, 0, 1, 16'hA000, 1, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 16'h9999, 0));
        tbl.push_back(mk(0, 0, 1, 16'h9999, 1, 1, 0, 16'h9999, 0));

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].clr, tbl[i].ld, tbl[i].val, tbl[i].ud, tbl[i].ci,
                 tbl[i].e_cout, tbl[i].e_q, tbl[i].e_err, $sformatf("vec%0d", i));

        // Alternating direction under continuous Cin
        m_val = 0; m_err = 1'b0;
        model_step(1, 0, 0, 16'h0000, 1, 0, "tog_rst");
        model_step(0, 0, 1, 16'h0998, 1, 0, "tog_ld");
        for (int i = 0; i < 30; i++)
            model_step(0, 0, 0, 16'h0000, (i % 2 == 0), 1, $sformatf("tog%0d", i));

        // Random stimulus, biased towards the wrap boundaries
        for (int i = 0; i < 400; i++) begin
            logic        r_rst, r_clr, r_ld, r_ud, r_ci;
            logic [15:0] r_val;
            r_rst = ($urandom_range(0, 49) == 0);
            r_clr = ($urandom_range(0, 29) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_ud  = 1'($urandom);
            r_ci  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       r_val = 16'h9999;
                1:       r_val = 16'h0000;
                2:       r_val = 16'h9990;
                default: r_val = 16'($urandom);
            endcase
            model_step(r_rst, r_clr, r_ld, r_val, r_ud, r_ci, $sformatf("rnd%0d", i));
        end

        // Two single-decade instances chained through Cout
        @(negedge Clk); c_rst = 1'b1; c_cin = 1'b0;
        @(negedge Clk); c_rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk) c_cin = 1'b1;
            @(negedge Clk) c_cin = 1'b0;
        end
        #1 chk("cascade30", {24'd0, c1_q, c0_q}, 32'h30);
        for (int i = 0; i < 25; i++) begin
            @(negedge Clk) c_cin = 1'b1;
            @(negedge Clk) c_cin = 1'b0;
        end
        #1 chk("cascade55", {24'd0, c1_q, c0_q}, 32'h55);
        chk("cascade_cout", {31'd0, c1_cout}, 32'd0);
        chk("cascade_err", {30'd0, c1_err, c0_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
